// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for the MEM stage: it samples a load or store request,
// holds the pipeline stall for LATENCY cycles, then commits the access and pulses ready.
module dmem_responder #(
   parameter int unsigned DEPTH_WORDS = 256,
   parameter int unsigned LATENCY     = 3
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_mem_read,
   input  logic        i_mem_write,
   input  logic [31:0] i_address,
   input  logic [31:0] i_write_data,
   output logic [31:0] o_read_data,
   output logic        o_ready,
   output logic        o_mem_stall,
   output logic        o_mem_error
);
   localparam int unsigned AW = $clog2(DEPTH_WORDS);
   localparam logic [3:0] CntInit = 4'(LATENCY - 1);

   typedef enum logic [1:0] {StIdle, StBusy, StDone} state_t;

   state_t        r_state, w_state_next;
   logic [3:0]    r_cnt, w_cnt_next;
   logic [AW-1:0] r_idx, w_idx;
   logic [31:0]   r_wdata, w_wdata;
   logic          r_write, w_write;
   logic          r_err, w_err;
   logic [31:0]   r_read_data;
   logic [31:0]   r_mem [DEPTH_WORDS];
   logic          w_req, w_take, w_commit;
   logic          w_unused;

   // Upper address bits are deliberately dropped so out-of-range addresses wrap.
   assign w_unused = ^i_address[31:AW+2];

   assign w_req  = i_mem_read | i_mem_write;
   assign w_take = (r_state == StIdle) && w_req;

   // With LATENCY=1 the commit happens on the sampling edge, so bypass the latches.
   assign w_idx   = w_take ? i_address[AW+1:2] : r_idx;
   assign w_wdata = w_take ? i_write_data : r_wdata;
   assign w_write = w_take ? i_mem_write : r_write;
   assign w_err   = w_take ? ((i_mem_read & i_mem_write) | (i_address[1:0] != 2'b00)) : r_err;

   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      unique case (r_state)
         StIdle: begin
            if (w_req) begin
               w_cnt_next   = CntInit;
               w_state_next = (CntInit == 4'd0) ? StDone : StBusy;
            end
         end
         StBusy: begin
            if (r_cnt <= 4'd1) begin
               w_cnt_next   = 4'd0;
               w_state_next = StDone;
            end else begin
               w_cnt_next = r_cnt - 4'd1;
            end
         end
         StDone:  w_state_next = StIdle;
         default: w_state_next = StIdle;
      endcase
   end

   assign w_commit = (w_state_next == StDone) && (r_state != StDone) && !w_err;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= StIdle;
         r_cnt       <= 4'd0;
         r_idx       <= '0;
         r_wdata     <= 32'd0;
         r_write     <= 1'b0;
         r_err       <= 1'b0;
         r_read_data <= 32'd0;
         for (int i = 0; i < int'(DEPTH_WORDS); i++) begin
            r_mem[i] <= 32'd0;
         end
      end else begin
         r_state <= w_state_next;
         r_cnt   <= w_cnt_next;
         if (w_take) begin
            r_idx   <= w_idx;
            r_wdata <= w_wdata;
            r_write <= w_write;
            r_err   <= w_err;
         end
         if (w_commit) begin
            if (w_write) begin
               r_mem[w_idx] <= w_wdata;
            end else begin
               r_read_data <= r_mem[w_idx];
            end
         end
      end
   end

   assign o_read_data = r_read_data;
   assign o_ready     = (r_state == StDone);
   assign o_mem_error = (r_state == StDone) && r_err;
   assign o_mem_stall = w_take || (r_state == StBusy);

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized scoreboard bench for dmem_responder: a word-array model predicts each response,
// and a negedge monitor checks every ready pulse for timing, error flag and load data.
module tb_dmem_responder;
   localparam int unsigned DEPTH = 256;
   localparam int unsigned LAT   = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        mem_read = 1'b0, mem_write = 1'b0;
   logic [31:0] address = 32'd0, write_data = 32'd0;
   logic [31:0] read_data;
   logic        ready, mem_stall, mem_error;

   dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_mem_read  (mem_read),
      .i_mem_write (mem_write),
      .i_address   (address),
      .i_write_data(write_data),
      .o_read_data (read_data),
      .o_ready     (ready),
      .o_mem_stall (mem_stall),
      .o_mem_error (mem_error)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          cyc;
      bit          err;
      logic [31:0] rdata;
   } exp_t;

   exp_t        sb_q[$];
   logic [31:0] mem_m [DEPTH];
   logic [31:0] rd_m;
   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got 0x%08h, expected 0x%08h", name, cyc, act, exp);
      end
   endtask

   // Monitor: every ready pulse must match the oldest outstanding request.
   always @(negedge clk) begin
      exp_t e;
      if (ready === 1'b1) begin
         if (sb_q.size() == 0) begin
            chk("unexpected_ready", 32'd1, 32'd0);
         end else begin
            e = sb_q.pop_front();
            chk("ready_cycle", cyc, e.cyc);
            chk("mem_error", {31'd0, mem_error}, {31'd0, e.err});
            chk("read_data", read_data, e.rdata);
         end
      end else if (mem_error === 1'b1) begin
         chk("error_without_ready", 32'd1, 32'd0);
      end
   end

   task automatic clear_model();
      for (int i = 0; i < int'(DEPTH); i++) mem_m[i] = 32'd0;
      rd_m = 32'd0;
   endtask

   // Called at a negedge with the DUT idle; returns at the negedge of the DONE cycle.
   task automatic req(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d,
                      input bit scramble);
      exp_t e;
      int   idx;
      e.err = (rd && wr) || (a[1:0] != 2'b00);
      idx   = int'((a >> 2) % DEPTH);
      if (!e.err) begin
         if (wr) mem_m[idx] = d;
         else    rd_m = mem_m[idx];
      end
      e.cyc   = cyc + int'(LAT);
      e.rdata = rd_m;
      sb_q.push_back(e);
      mem_read = rd; mem_write = wr; address = a; write_data = d;
      for (int k = 0; k < int'(LAT); k++) begin
         #1 chk("stall_during_access", {31'd0, mem_stall}, 32'd1);
         @(negedge clk);
         if (scramble) begin
            address    = $urandom;
            write_data = $urandom;
         end
      end
      #1 chk("stall_in_done", {31'd0, mem_stall}, 32'd0);
      mem_read = 1'b0; mem_write = 1'b0;
   endtask

   task automatic idle(input int n);
      mem_read = 1'b0; mem_write = 1'b0;
      repeat (n) @(negedge clk);
      #1 chk("idle_stall", {31'd0, mem_stall}, 32'd0);
      chk("held_read_data", read_data, rd_m);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] a;
      int          op;
      clear_model();
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("reset_read_data", read_data, 32'd0);
      chk("reset_ready", {31'd0, ready}, 32'd0);
      chk("reset_error", {31'd0, mem_error}, 32'd0);
      chk("reset_stall", {31'd0, mem_stall}, 32'd0);
      @(negedge clk);

      req(0, 1, 32'h10, 32'hDEADBEEF, 0);
      @(negedge clk);
      req(1, 0, 32'h10, 32'h0, 0);
      idle(10);
      req(0, 1, 32'h12, 32'h1234, 0);
      @(negedge clk);
      req(1, 0, 32'h10, 32'h0, 0);
      @(negedge clk);
      req(1, 1, 32'h10, 32'h55, 0);
      @(negedge clk);
      req(1, 0, 32'h10, 32'h0, 0);
      @(negedge clk);
      req(0, 1, 32'h400, 32'hA5A5A5A5, 0);
      @(negedge clk);
      req(1, 0, 32'h0, 32'h0, 0);
      @(negedge clk);
      req(0, 1, 32'h30, 32'hCAFEF00D, 1);
      @(negedge clk);
      req(1, 0, 32'h30, 32'h0, 1);
      idle(2);

      // Reset in the first BUSY cycle aborts the store and clears everything.
      mem_write = 1'b1; address = 32'h20; write_data = 32'h77777777;
      #1 chk("abort_stall", {31'd0, mem_stall}, 32'd1);
      @(negedge clk);
      rst = 1'b1; mem_write = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      clear_model();
      #1 chk("post_reset_stall", {31'd0, mem_stall}, 32'd0);
      chk("post_reset_read_data", read_data, 32'd0);
      idle(4);
      req(1, 0, 32'h20, 32'h0, 0);
      @(negedge clk);
      req(0, 1, 32'h8, 32'h13572468, 0);
      @(negedge clk);
      req(1, 0, 32'h8, 32'h0, 0);
      @(negedge clk);

      for (int n = 0; n < 300; n++) begin
         a = $urandom;
         a[9:6] = 4'd0;
         if ($urandom_range(0, 4) != 0) a[1:0] = 2'b00;
         op = $urandom_range(0, 9);
         if (op < 5)      req(1, 0, a, $urandom, $urandom_range(0, 1) == 1);
         else if (op < 9) req(0, 1, a, $urandom, $urandom_range(0, 1) == 1);
         else             req(1, 1, a, $urandom, 0);
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
         else                           @(negedge clk);
      end

      idle(6);
      chk("scoreboard_drained", sb_q.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
